// File: rtl/pe_acc_param.sv
// Multi-channel signed dot-product PE: TAPS-wide MAC per beat, accumulated over ch_num+1 beats,
// then bias, rounding shift, optional ReLU and saturation back to DW bits.

module pe_mul_lane #(
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DW-1:0]          a_i,
    input  logic [DW-1:0]          b_i,
    output logic signed [2*DW-1:0] p_o
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) p_o <= '0;
        else        p_o <= $signed(a_i) * $signed(b_i);
    end
endmodule

module pe_acc_param #(
    parameter int DW    = 8,
    parameter int TAPS  = 9,
    parameter int CH_W  = 4,
    parameter int SH_W  = 3,
    parameter int ACC_W = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW*TAPS-1:0]   in,
    input  logic [DW*TAPS-1:0]   weight,
    input  logic [15:0]          bias,
    input  logic [SH_W-1:0]      shift,
    input  logic                 relu_en,
    input  logic [CH_W-1:0]      ch_num,
    input  logic                 en,
    output logic [DW-1:0]        out,
    output logic                 out_en,
    output logic                 busy
);
    // Per-beat group config travels with the beat, so a new group latching fresh
    // config cannot corrupt the tail of the previous group still in the pipeline.
    typedef struct packed {
        logic            first;
        logic            last;
        logic [15:0]     bias;
        logic [SH_W-1:0] shift;
        logic            relu;
    } meta_t;

    logic [CH_W-1:0]          cnt_q, cnt_d, ch_q;
    logic [15:0]              bias_q;
    logic [SH_W-1:0]          shift_q, sh3_q;
    logic                     relu_q, relu3_q;
    logic                     first_b, last_b;
    meta_t                    meta_d;
    meta_t                    meta_q [3];
    logic [3:0]               vld_pipe;
    logic [DW*TAPS-1:0]       in_q, w_q;
    logic signed [2*DW-1:0]   prod [TAPS];
    logic signed [ACC_W-1:0]  sum_d, sum_q, acc_q, acc_new;
    logic signed [ACC_W:0]    res_q, rnd, shr;
    logic [DW-1:0]            out_q, out_d;
    logic                     out_en_q;

    localparam logic signed [ACC_W:0] SMAX = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        first_b = (cnt_q == '0);
        last_b  = (cnt_q == (first_b ? ch_num : ch_q));
        cnt_d   = cnt_q;
        if (en) cnt_d = last_b ? '0 : cnt_q + 1'b1;
        meta_d.first = first_b;
        meta_d.last  = last_b;
        meta_d.bias  = first_b ? bias    : bias_q;
        meta_d.shift = first_b ? shift   : shift_q;
        meta_d.relu  = first_b ? relu_en : relu_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ch_q    <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            in_q    <= '0;
            w_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en && first_b) begin
                ch_q    <= ch_num;
                bias_q  <= bias;
                shift_q <= shift;
                relu_q  <= relu_en;
            end
            if (en) begin
                in_q <= in;
                w_q  <= weight;
            end
        end
    end

    // tap0 sits in the MSBs of the flat vectors
    for (genvar t = 0; t < TAPS; t++) begin : g_lane
        pe_mul_lane #(.DW(DW)) u_mul (
            .clk   (clk),
            .reset (reset),
            .a_i   (in_q[DW*(TAPS-t)-1 -: DW]),
            .b_i   (w_q[DW*(TAPS-t)-1 -: DW]),
            .p_o   (prod[t])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int t = 0; t < TAPS; t++) sum_d = sum_d + ACC_W'(prod[t]);
        acc_new = meta_q[2].first ? sum_q : acc_q + sum_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < 3; i++) meta_q[i] <= '0;
            sum_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            sh3_q    <= '0;
            relu3_q  <= 1'b0;
            out_q    <= '0;
            out_en_q <= 1'b0;
        end else begin
            vld_pipe[0] <= en;
            if (en) meta_q[0] <= meta_d;
            vld_pipe[1] <= vld_pipe[0];
            meta_q[1]   <= meta_q[0];
            vld_pipe[2] <= vld_pipe[1];
            meta_q[2]   <= meta_q[1];
            sum_q       <= sum_d;
            // stage 3 only carries completed groups
            vld_pipe[3] <= vld_pipe[2] & meta_q[2].last;
            if (vld_pipe[2]) acc_q <= acc_new;
            if (vld_pipe[2] && meta_q[2].last) begin
                res_q   <= (ACC_W+1)'(acc_new) + (ACC_W+1)'($signed(meta_q[2].bias));
                sh3_q   <= meta_q[2].shift;
                relu3_q <= meta_q[2].relu;
            end
            out_en_q <= vld_pipe[3];
            if (vld_pipe[3]) out_q <= out_d;
        end
    end

    // round half up, then ReLU, then clamp to the signed DW range
    always_comb begin
        rnd = ((ACC_W+1)'(1) << sh3_q) >> 1;
        shr = (res_q + rnd) >>> sh3_q;
        if (relu3_q && shr[ACC_W]) shr = '0;
        if (shr > SMAX)      out_d = {1'b0, {(DW-1){1'b1}}};
        else if (shr < SMIN) out_d = {1'b1, {(DW-1){1'b0}}};
        else                 out_d = shr[DW-1:0];
    end

    assign out    = out_q;
    assign out_en = out_en_q;
    assign busy   = (cnt_q != '0) || (|vld_pipe) || out_en_q;

endmodule

// File: tb/tb_pe_acc_param.sv
// Directed bench for pe_acc_param: latency, accumulation, requant, back-to-back groups, async reset.

module tb_pe_acc_param;
    localparam int DW = 8, TAPS = 9, CH_W = 4, SH_W = 3, ACC_W = 26;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [DW*TAPS-1:0]  din = '0, dw = '0;
    logic [15:0]         bias = '0;
    logic [SH_W-1:0]     shift = '0;
    logic                relu_en = 1'b0;
    logic [CH_W-1:0]     ch_num = '0;
    logic                en = 1'b0;
    logic [DW-1:0]       out;
    logic                out_en, busy;

    int tests = 0;
    int fails = 0;

    pe_acc_param #(.DW(DW), .TAPS(TAPS), .CH_W(CH_W), .SH_W(SH_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(rst_n), .in(din), .weight(dw), .bias(bias), .shift(shift),
        .relu_en(relu_en), .ch_num(ch_num), .en(en), .out(out), .out_en(out_en), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*TAPS-1:0] rep(input logic [DW-1:0] b);
        rep = {TAPS{b}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW*TAPS-1:0] a, input logic [DW*TAPS-1:0] b);
        din = a; dw = b; en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic cfg(input logic [CH_W-1:0] c, input logic [15:0] bi, input logic [SH_W-1:0] s,
                       input logic r);
        ch_num = c; bias = bi; shift = s; relu_en = r;
    endtask

    // cycles from the last beat's edge until out_en; -1 if it never arrives
    task automatic wait_pulse(output int lat, output logic [DW-1:0] val);
        lat = -1; val = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_en === 1'b1) begin lat = i; val = out; return; end
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        tick(); tick();
        tests++; if (out !== 8'h00)  begin fails++; $display("FAIL reset_out got %h want 00", out); end
        tests++; if (out_en !== 1'b0) begin fails++; $display("FAIL reset_out_en got %b want 0", out_en); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int lat; logic [DW-1:0] v;
        cfg(0, 16'h0000, 0, 1'b0);
        beat(rep(8'h01), rep(8'h01));
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
        wait_pulse(lat, v);
        tests++; if (lat != 4)   begin fails++; $display("FAIL single_latency got %0d want 4", lat); end
        tests++; if (v !== 8'h09) begin fails++; $display("FAIL single_out got %h want 09", v); end
        tick();
        tests++; if (out_en !== 1'b0) begin fails++; $display("FAIL single_width got %b want 0", out_en); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL single_busy_low got %b want 0", busy); end
        tests++; if (out !== 8'h09)   begin fails++; $display("FAIL single_hold got %h want 09", out); end
    endtask

    task automatic test_accum;
        int lat; logic [DW-1:0] v;
        cfg(3, 16'h0000, 1, 1'b0);
        beat(rep(8'h02), rep(8'h03));
        cfg(0, 16'h7FFF, 0, 1'b1);   // must be ignored mid-group
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        wait_pulse(lat, v);
        tests++; if (lat != 4)   begin fails++; $display("FAIL accum_latency got %0d want 4", lat); end
        tests++; if (v !== 8'h6C) begin fails++; $display("FAIL accum_out got %h want 6C", v); end
        tick(); tick();
        cfg(3, 16'h0000, 1, 1'b0);
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        tick(); tick();
        tests++; if (out_en !== 1'b0) begin fails++; $display("FAIL gap_early got %b want 0", out_en); end
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        wait_pulse(lat, v);
        tests++; if (lat != 4)   begin fails++; $display("FAIL gap_latency got %0d want 4", lat); end
        tests++; if (v !== 8'h6C) begin fails++; $display("FAIL gap_out got %h want 6C", v); end
        tick(); tick();
    endtask

    task automatic test_saturation;
        int lat; logic [DW-1:0] v;
        cfg(0, 16'h0000, 0, 1'b0);
        beat(rep(8'h7F), rep(8'h7F)); wait_pulse(lat, v);
        tests++; if (v !== 8'h7F) begin fails++; $display("FAIL sat_pos got %h want 7F", v); end
        beat(rep(8'h80), rep(8'h7F)); wait_pulse(lat, v);
        tests++; if (v !== 8'h80) begin fails++; $display("FAIL sat_neg got %h want 80", v); end
        cfg(0, 16'h0000, 0, 1'b1);
        beat(rep(8'h80), rep(8'h7F)); wait_pulse(lat, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL relu_neg got %h want 00", v); end
        beat(rep(8'h7F), rep(8'h7F)); wait_pulse(lat, v);
        tests++; if (v !== 8'h7F) begin fails++; $display("FAIL relu_pos got %h want 7F", v); end
        tick();
    endtask

    task automatic test_bias_round;
        int lat; logic [DW-1:0] v;
        logic [DW*TAPS-1:0] five_p, five_n;
        five_p = {{5{8'h01}}, {4{8'h00}}};
        five_n = {{5{8'hFF}}, {4{8'h00}}};
        cfg(0, 16'hFFF6, 0, 1'b0);
        beat(rep(8'h01), rep(8'h01)); wait_pulse(lat, v);
        tests++; if (v !== 8'hFF) begin fails++; $display("FAIL bias_neg got %h want FF", v); end
        cfg(0, 16'h0000, 1, 1'b0);
        beat(five_p, rep(8'h01)); wait_pulse(lat, v);
        tests++; if (v !== 8'h03) begin fails++; $display("FAIL round_pos got %h want 03", v); end
        beat(five_n, rep(8'h01)); wait_pulse(lat, v);
        tests++; if (v !== 8'hFE) begin fails++; $display("FAIL round_neg got %h want FE", v); end
        cfg(0, 16'h0000, 2, 1'b0);
        beat(rep(8'h01), rep(8'h01)); wait_pulse(lat, v);  // (9+2)>>2 = 2
        tests++; if (v !== 8'h02) begin fails++; $display("FAIL round_sh2 got %h want 02", v); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [DW*TAPS-1:0] va [6];
        logic [DW*TAPS-1:0] vb [6];
        logic               exp_oe, exp_busy;
        logic [DW-1:0]      exp_v;
        va[0] = rep(8'h01); vb[0] = rep(8'h01);   //  9
        va[1] = rep(8'h02); vb[1] = rep(8'h01);   // 18 -> 27
        va[2] = rep(8'h03); vb[2] = rep(8'h01);   // 27
        va[3] = rep(8'hFF); vb[3] = rep(8'h02);   // -18 -> 9
        va[4] = rep(8'h01); vb[4] = rep(8'h05);   // 45
        va[5] = rep(8'h00); vb[5] = rep(8'h07);   //  0 -> 45
        cfg(1, 16'h0000, 0, 1'b0);
        for (int c = 0; c < 13; c++) begin
            if (c < 6) begin din = va[c]; dw = vb[c]; en = 1'b1; end
            else en = 1'b0;
            tick();
            exp_oe   = (c == 5) || (c == 7) || (c == 9);
            exp_busy = (c <= 9);
            exp_v    = (c == 5) ? 8'h1B : (c == 7) ? 8'h09 : 8'h2D;
            tests++;
            if (out_en !== exp_oe) begin
                fails++; $display("FAIL b2b_out_en c=%0d got %b want %b", c, out_en, exp_oe);
            end
            tests++;
            if (busy !== exp_busy) begin
                fails++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, exp_busy);
            end
            if (exp_oe) begin
                tests++;
                if (out !== exp_v) begin
                    fails++; $display("FAIL b2b_out c=%0d got %h want %h", c, out, exp_v);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        int lat; logic [DW-1:0] v;
        cfg(3, 16'h0000, 1, 1'b0);
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out !== 8'h00)  begin fails++; $display("FAIL areset_out got %h want 00", out); end
        tests++; if (out_en !== 1'b0) begin fails++; $display("FAIL areset_out_en got %b want 0", out_en); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL areset_busy got %b want 0", busy); end
        #2 rst_n = 1'b1;
        tick();
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        beat(rep(8'h02), rep(8'h03));
        wait_pulse(lat, v);
        tests++; if (lat != 4)   begin fails++; $display("FAIL areset_latency got %0d want 4", lat); end
        tests++; if (v !== 8'h6C) begin fails++; $display("FAIL areset_fresh got %h want 6C", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_accum();
        test_saturation();
        test_bias_round();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_acc_param.md
Name: pe_acc_param

Overview:
- Parametrised multi-channel successor of the 3x3 PE.
- Performs a TAPS-wide signed dot product of input vs weight vectors each accepted beat, and accumulates ch_num+1 beats (input channels) into one result.
- Result gets bias, rounding right-shift requantisation, optional ReLU and saturation back to DW bits.
- Sits between the window/line-buffer feeder and the output buffer; streams back-to-back results with no bubbles.

Parameters:
DW, 8, data/weight/output width (signed two's complement)
TAPS, 9, taps per beat (3x3 kernel)
CH_W, 4, width of ch_num; up to 2^CH_W channels per result
SH_W, 3, width of shift
ACC_W, 26, accumulator width; must be >= 2*DW+clog2(TAPS)+CH_W+1 (overflow impossible by construction)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in  in  DW*TAPS  input taps, tap0 in MSBs
weight  in  DW*TAPS  weight taps, tap0 in MSBs
bias  in  16  signed bias, sign-extended to ACC_W
shift  in  SH_W  arithmetic right-shift amount for requantisation
relu_en  in  1  1 = clamp negative results to 0
ch_num  in  CH_W  channels per result minus 1
en  in  1  beat valid; in/weight sampled when high
out  out  DW  signed result, holds last value between results
out_en  out  1  one-cycle pulse, out valid
busy  out  1  group in progress or result in pipeline

Behaviour:
- Reset (reset=0, async): out=0, out_en=0, busy=0. Channel counter, all pipeline valid flags and the accumulator are cleared; partial group discarded. Release is synchronous to the next clk edge.
- Channel counter cnt:
  - IDLE when cnt=0 and no group open.
  - Beat accepted (en=1): if first beat of a group, latch ch_num, bias, shift and relu_en for the whole group. Later changes on these inputs are ignored until the next group.
  - Beat is last when cnt==latched ch_num; then cnt->0, else cnt+1.
  - ch_num=0 means single-beat groups.
  - en=0 cycles within a group insert gaps; the result is unaffected.
- Pipeline, beat accepted at edge k, with first/last flags carried alongside:
  - k+1: TAPS signed products registered (2*DW each).
  - k+2: adder tree sum registered.
  - k+3: accumulator: acc = sum if first, else acc + sum. On last, result = acc_new + bias.
  - k+4: requant stage drives out and pulses out_en for exactly one cycle.
- Latency from the last beat's en edge to out_en high is 4 cycles.
- Back-to-back groups: a new group's first beat may follow the last beat on the next cycle. The accumulator load-vs-add is decided by the pipelined first flag, so there is no mixing between groups.
- Requant:
  - r = (result + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (round half up).
  - If relu_en and r<0, r=0.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
- busy:
  - Goes high on the edge accepting a first beat.
  - Stays high while a group is open or any valid flag is set in the pipeline.
  - Goes low the cycle after the final out_en when no new group started.
- Simultaneous events: last beat of group A and first beat of group B never collide (one beat per cycle). out_en of A and accumulation of B proceed concurrently.

Test Plan:
1. ch_num=0, in all 0x01, weights all 0x01, bias=0, shift=0, one en beat -> out=0x09, out_en high exactly 4 cycles after beat, one cycle wide.
2. ch_num=3, 4 beats in=0x02, w=0x03, shift=1 -> acc=216, out=0x6C (108). Repeat with en low for 2 cycles between beats 2 and 3 -> same 0x6C, out_en 4 cycles after beat 4.
3. Saturation, ch_num=0, shift=0:
   - in=0x7F, w=0x7F -> out=0x7F.
   - in=0x80, w=0x7F -> out=0x80.
   - Same with relu_en=1 -> out=0x00.
4. Bias and rounding:
   - Sum 9, bias=16'hFFF6 -> out=0xFF.
   - Sum 5, shift=1 -> 0x03.
   - Sum -5, shift=1 -> 0xFE.
5. ch_num=1, 6 consecutive en beats with distinct vectors -> 3 out_en pulses spaced 2 cycles apart, each equal to its own pair sum (no carry-over), busy continuous until the last pulse.
6. reset=0 asynchronously after beat 2 of a 4-beat group -> out=0, out_en=0, busy=0 immediately. After release, a fresh 4-beat group of case 2 -> 0x6C.
